// File: rtl/card_dealer.sv
// Card-request responder: fetches the next deck card and adds its value to the addressed hand.
// Optional macro CARD_DEALER_SOFT_ACE_EN: aces count 11 with soft-ace correction; otherwise aces count 1.
module card_dealer #(
   parameter int DECK_SIZE = 52,
   parameter int HAND_W    = 6
) (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   input  logic              i_Clear,
   input  logic              i_Card2Player,
   input  logic              i_Card2Dealer,
   output logic              o_CardOK,
   output logic [HAND_W-1:0] o_HandP,
   output logic [HAND_W-1:0] o_HandD,
   output logic [3:0]        o_LastCard,
   output logic [5:0]        o_DeckAddr,
   input  logic [3:0]        i_DeckData,
   output logic              o_DeckWrap
);

   typedef enum logic [2:0] {IDLE, FETCH, ADD, ACK, GAP} state_t;

   localparam logic [5:0] LAST_ADDR = 6'(DECK_SIZE - 1);

   state_t            state;
   logic              to_dealer;
   logic [HAND_W-1:0] cur_hand;
   logic [HAND_W-1:0] new_hand;
   logic [HAND_W:0]   sum;
   logic [3:0]        val;

`ifdef CARD_DEALER_SOFT_ACE_EN
   logic [3:0] soft_p, soft_d;
   logic [3:0] cur_soft, new_soft;
`endif

   always_comb begin
      cur_hand = to_dealer ? o_HandD : o_HandP;
      val      = (i_DeckData >= 4'd10) ? 4'd10 : i_DeckData;
`ifdef CARD_DEALER_SOFT_ACE_EN
      cur_soft = to_dealer ? soft_d : soft_p;
      new_soft = cur_soft;
      if (i_DeckData == 4'd1) begin
         val      = 4'd11;
         new_soft = cur_soft + 4'd1;
      end
      sum = {1'b0, cur_hand} + (HAND_W+1)'(val);
      // a single card can push the total over by at most one ace's worth
      if (sum > (HAND_W+1)'(21) && new_soft != 4'd0) begin
         sum      = sum - (HAND_W+1)'(10);
         new_soft = new_soft - 4'd1;
      end
`else
      sum = {1'b0, cur_hand} + (HAND_W+1)'(val);
`endif
      new_hand = sum[HAND_W-1:0];
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state      <= IDLE;
         to_dealer  <= 1'b0;
         o_CardOK   <= 1'b0;
         o_HandP    <= '0;
         o_HandD    <= '0;
         o_LastCard <= 4'd0;
         o_DeckAddr <= 6'd0;
         o_DeckWrap <= 1'b0;
`ifdef CARD_DEALER_SOFT_ACE_EN
         soft_p     <= 4'd0;
         soft_d     <= 4'd0;
`endif
      end else if (i_Clear) begin
         state      <= IDLE;
         to_dealer  <= 1'b0;
         o_CardOK   <= 1'b0;
         o_HandP    <= '0;
         o_HandD    <= '0;
         o_LastCard <= 4'd0;
         o_DeckAddr <= 6'd0;
         o_DeckWrap <= 1'b0;
`ifdef CARD_DEALER_SOFT_ACE_EN
         soft_p     <= 4'd0;
         soft_d     <= 4'd0;
`endif
      end else begin
         o_CardOK <= 1'b0;
         case (state)
            IDLE: begin
               if (i_Card2Player) begin
                  to_dealer <= 1'b0;
                  state     <= FETCH;
               end else if (i_Card2Dealer) begin
                  to_dealer <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: state <= ADD;
            ADD: begin
               if (to_dealer) o_HandD <= new_hand;
               else           o_HandP <= new_hand;
`ifdef CARD_DEALER_SOFT_ACE_EN
               if (to_dealer) soft_d <= new_soft;
               else           soft_p <= new_soft;
`endif
               o_LastCard <= i_DeckData;
               if (o_DeckAddr == LAST_ADDR) begin
                  o_DeckAddr <= 6'd0;
                  o_DeckWrap <= 1'b1;
               end else begin
                  o_DeckAddr <= o_DeckAddr + 6'd1;
               end
               o_CardOK <= 1'b1;
               state    <= ACK;
            end
            ACK: state <= GAP;
            // controller still shows its old request during ACK; skip one cycle
            GAP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer with a registered-read deck memory model.
module tb_card_dealer;

   localparam int DECK_SIZE = 52;
   localparam int HAND_W    = 6;

`ifdef CARD_DEALER_SOFT_ACE_EN
   localparam int ACE = 1;
`else
   localparam int ACE = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              req_p = 1'b0;
   logic              req_d = 1'b0;
   logic              card_ok;
   logic [HAND_W-1:0] hand_p, hand_d;
   logic [3:0]        last_card;
   logic [5:0]        deck_addr;
   logic [3:0]        deck_data;
   logic              deck_wrap;

   logic [3:0] deck [0:63];
   int compared = 0;
   int mismatched = 0;
   int pulses = 0;
   int base;

   card_dealer #(.DECK_SIZE(DECK_SIZE), .HAND_W(HAND_W)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_Clear(clear),
      .i_Card2Player(req_p), .i_Card2Dealer(req_d),
      .o_CardOK(card_ok), .o_HandP(hand_p), .o_HandD(hand_d),
      .o_LastCard(last_card), .o_DeckAddr(deck_addr),
      .i_DeckData(deck_data), .o_DeckWrap(deck_wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) deck_data <= deck[deck_addr];

   always @(negedge clk) if (card_ok === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
   task automatic deal(input logic p, input logic d, input bit checks, input string tag);
      int n = 0;
      req_p = p;
      req_d = d;
      do begin
         @(negedge clk);
         n++;
      end while (card_ok !== 1'b1 && n < 12);
      if (checks) begin
         chk({tag, " latency"}, n, 3);
         chk({tag, " p<=31"}, 32'(hand_p <= 31), 1);
         chk({tag, " d<=31"}, 32'(hand_d <= 31), 1);
      end
      @(negedge clk);
      if (checks) chk({tag, " ok one-cycle"}, card_ok, 0);
      req_p = 1'b0;
      req_d = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) deck[i] = 4'd2;

      // reset state
      deck[0] = 4'd7;
      repeat (2) @(negedge clk);
      chk("rst ok", card_ok, 0);
      chk("rst handp", hand_p, 0);
      chk("rst handd", hand_d, 0);
      chk("rst last", last_card, 0);
      chk("rst addr", deck_addr, 0);
      chk("rst wrap", deck_wrap, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single player deal
      deal(1'b1, 1'b0, 1'b1, "p7");
      chk("p7 handp", hand_p, 7);
      chk("p7 handd", hand_d, 0);
      chk("p7 addr", deck_addr, 1);
      chk("p7 last", last_card, 7);
      chk("p7 pulses", pulses, 1);

      // P,D,P,D controller-style
      do_clear();
      deck[0] = 4'd5; deck[1] = 4'd12; deck[2] = 4'd1; deck[3] = 4'd1;
      base = pulses;
      deal(1'b1, 1'b0, 1'b1, "s1");
      chk("s1 handp", hand_p, 5);
      deal(1'b0, 1'b1, 1'b1, "s2");
      chk("s2 handd", hand_d, 10);
      deal(1'b1, 1'b0, 1'b1, "s3");
      chk("s3 handp", hand_p, ACE ? 16 : 6);
      deal(1'b0, 1'b1, 1'b1, "s4");
      chk("s4 handd", hand_d, ACE ? 21 : 11);
      chk("s4 handp", hand_p, ACE ? 16 : 6);
      chk("s4 pulses", pulses - base, 4);
      chk("s4 addr", deck_addr, 4);
      chk("s4 last", last_card, 1);

      // two aces then a nine
      do_clear();
      deck[0] = 4'd1; deck[1] = 4'd1; deck[2] = 4'd9;
      deal(1'b1, 1'b0, 1'b1, "a1");
      chk("a1 handp", hand_p, ACE ? 11 : 1);
      deal(1'b1, 1'b0, 1'b1, "a2");
      chk("a2 handp", hand_p, ACE ? 12 : 2);
      deal(1'b1, 1'b0, 1'b1, "a3");
      chk("a3 handp", hand_p, ACE ? 21 : 11);

      // both requests high: player first, then dealer
      do_clear();
      deck[0] = 4'd4; deck[1] = 4'd6;
      begin
         int n = 0;
         req_p = 1'b1;
         req_d = 1'b1;
         do begin @(negedge clk); n++; end while (card_ok !== 1'b1 && n < 12);
         chk("both lat", n, 3);
         chk("both handp", hand_p, 4);
         chk("both handd", hand_d, 0);
         @(negedge clk);
         req_p = 1'b0;
         n = 0;
         do begin @(negedge clk); n++; end while (card_ok !== 1'b1 && n < 12);
         chk("dnext lat", n, 4);
         chk("dnext handd", hand_d, 6);
         chk("dnext handp", hand_p, 4);
         @(negedge clk);
         req_d = 1'b0;
         @(negedge clk);
      end

      // pointer wrap
      do_clear();
      chk("clr handp", hand_p, 0);
      chk("clr handd", hand_d, 0);
      chk("clr last", last_card, 0);
      for (int i = 0; i < 64; i++) deck[i] = 4'd2;
      for (int i = 0; i < DECK_SIZE - 1; i++) deal(i[0], ~i[0], 1'b0, "wr");
      chk("wr51 addr", deck_addr, DECK_SIZE - 1);
      chk("wr51 wrap", deck_wrap, 0);
      deal(1'b1, 1'b0, 1'b0, "wr52");
      chk("wr52 addr", deck_addr, 0);
      chk("wr52 wrap", deck_wrap, 1);
      deal(1'b0, 1'b1, 1'b0, "wr53");
      chk("wr53 addr", deck_addr, 1);
      chk("wr53 wrap", deck_wrap, 1);
      do_clear();
      chk("wclr addr", deck_addr, 0);
      chk("wclr wrap", deck_wrap, 0);
      chk("wclr last", last_card, 0);
      chk("wclr handp", hand_p, 0);
      chk("wclr handd", hand_d, 0);

      // clear during FETCH aborts the deal
      deck[0] = 4'd3; deck[1] = 4'd2;
      deal(1'b1, 1'b0, 1'b1, "pre");
      chk("pre handp", hand_p, 3);
      base = pulses;
      req_p = 1'b1;
      @(negedge clk);
      clear = 1'b1;
      req_p = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      repeat (6) @(negedge clk);
      chk("cf pulses", pulses - base, 0);
      chk("cf handp", hand_p, 0);
      chk("cf addr", deck_addr, 0);
      deal(1'b1, 1'b0, 1'b1, "cf next");
      chk("cf next handp", hand_p, 3);

      // async reset during ADD
      base = pulses;
      req_d = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar ok", card_ok, 0);
      chk("ar handp", hand_p, 0);
      chk("ar handd", hand_d, 0);
      chk("ar addr", deck_addr, 0);
      req_d = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("ar pulses", pulses - base, 0);
      chk("ar handd2", hand_d, 0);
      deal(1'b0, 1'b1, 1'b1, "ar next");
      chk("ar next handd", hand_d, 3);
      chk("ar next addr", deck_addr, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
